// File: rtl/cpu_pkg.sv
// Shared types and defaults for the operand fetch path.
// Holds the fetch FSM states and default register-file geometry.
package cpu_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_ZERO_REG = 31;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE2,
        CAPT2,
        RESP
    } fetch_state_t;

endpackage

// File: rtl/operand_slot.sv
// One operand of a fetch: address, write-forward capture, held value.
// Merges snooped writes so the operand is never stale.
module operand_slot
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              issue_i,
    input  logic              capture_i,
    input  logic              hold_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] op_o
);

    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              fwd_q, fwd_d;
    logic [DATA_W-1:0] fwdv_q, fwdv_d;
    logic [DATA_W-1:0] op_q, op_d;

    logic [ADDR_W-1:0] cmp_addr;
    logic              is_zero;
    logic              hit;

    // Address being fetched this cycle: incoming one on load, else latched.
    always_comb begin
        cmp_addr = load_i ? load_addr_i : addr_q;
        is_zero  = (cmp_addr == ZR);
        hit      = wr_en_i && (wr_addr_i == cmp_addr) && !is_zero;
    end

    // Next state: latch addr, note issue-cycle hits, capture with priority, track hold hits.
    always_comb begin
        addr_d = addr_q;
        fwd_d  = fwd_q;
        fwdv_d = fwdv_q;
        op_d   = op_q;
        if (load_i) begin
            addr_d = load_addr_i;
        end
        if (issue_i) begin
            fwd_d = hit;
            if (hit) begin
                fwdv_d = wr_data_i;
            end
        end
        if (capture_i) begin
            if (is_zero) begin
                op_d = '0;
            end else if (hit) begin
                op_d = wr_data_i;
            end else if (fwd_q) begin
                op_d = fwdv_q;
            end else begin
                op_d = mem_rdata_i;
            end
        end else if (hold_i && hit) begin
            op_d = wr_data_i;
        end
    end

    // Slot registers, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
            fwd_q  <= 1'b0;
            fwdv_q <= '0;
            op_q   <= '0;
        end else begin
            addr_q <= addr_d;
            fwd_q  <= fwd_d;
            fwdv_q <= fwdv_d;
            op_q   <= op_d;
        end
    end

    assign addr_o = addr_q;
    assign op_o   = op_q;

endmodule

// File: rtl/operand_fetch_seq.sv
// Two-operand fetch over one synchronous read port.
// Sequences two reads, forwards in-flight writes, returns both values.
module operand_fetch_seq
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [ADDR_W-1:0] req_addr2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data1,
    output logic [DATA_W-1:0] rsp_data2,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    fetch_state_t state_q;
    logic         rsp_valid_q;

    logic              accept;
    logic              in_issue2;
    logic              in_capt2;
    logic              rsp_hold;
    logic [ADDR_W-1:0] addr2;

    // Handshake and per-state strobes; reset masks the port outputs.
    always_comb begin
        req_ready = reset && (state_q == IDLE);
        accept    = req_valid && req_ready;
        in_issue2 = reset && (state_q == ISSUE2);
        in_capt2  = (state_q == CAPT2);
        rsp_hold  = (state_q == RESP) && !rsp_ready;
    end

    // Read port: operand 1 on accept, operand 2 in ISSUE2.
    always_comb begin
        mem_rd_en = accept || in_issue2;
        mem_addr  = '0;
        if (accept) begin
            mem_addr = req_addr1;
        end else if (in_issue2) begin
            mem_addr = addr2;
        end
    end

    // Fetch sequencer with registered response valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ISSUE2;
                    end
                end
                ISSUE2: begin
                    state_q <= CAPT2;
                end
                CAPT2: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;

    logic [ADDR_W-1:0] addr1_unused;

    operand_slot #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_slot1 (
        .clk         (clk),
        .reset       (reset),
        .load_i      (accept),
        .load_addr_i (req_addr1),
        .issue_i     (accept),
        .capture_i   (in_issue2),
        .hold_i      (in_capt2 || rsp_hold),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .mem_rdata_i (mem_rdata),
        .addr_o      (addr1_unused),
        .op_o        (rsp_data1)
    );

    operand_slot #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_slot2 (
        .clk         (clk),
        .reset       (reset),
        .load_i      (accept),
        .load_addr_i (req_addr2),
        .issue_i     (in_issue2),
        .capture_i   (in_capt2),
        .hold_i      (rsp_hold),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .mem_rdata_i (mem_rdata),
        .addr_o      (addr2),
        .op_o        (rsp_data2)
    );

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Bench for operand_fetch_seq: vector table plus hand sequences,
// with a response scoreboard and a behavioural register storage.
module tb_operand_fetch_seq;
    import cpu_pkg::*;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NV = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_addr1 = '0;
    logic [AW-1:0] req_addr2 = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_data1;
    logic [DW-1:0] rsp_data2;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;

    always #5 clk = ~clk;

    operand_fetch_seq dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr1 (req_addr1),
        .req_addr2 (req_addr2),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data1 (rsp_data1),
        .rsp_data2 (rsp_data2),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    // Register storage: read sees the value before a same-edge write.
    logic [DW-1:0] mem [32];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Response monitor: pop expected values on every accepted response.
    always @(negedge clk) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got %h/%h expected none", rsp_data1, rsp_data2);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_data1", rsp_data1, mon_e.d1);
                chk("rsp_data2", rsp_data2, mon_e.d2);
            end
        end
    end

    typedef struct {
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        int            wc;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;
    vec_t tv[NV];

    task automatic set_wr(input int i, input int c);
        wr_en   = (tv[i].wc == c);
        wr_addr = tv[i].wa;
        wr_data = tv[i].wd;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        req_valid = 1'b1;
        req_addr1 = a1;
        req_addr2 = a2;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) mem[i] = 64'h1000 + 64'(i);
        mem[3]  = 64'hAA;
        mem[7]  = 64'hBB;
        mem[5]  = 64'h1;
        mem[4]  = 64'h9;
        mem[31] = 64'hFFFF;

        tv[0]  = '{5'd3,  5'd7,  -1, 5'd0,  64'h0,    64'hAA,   64'hBB};
        tv[1]  = '{5'd5,  5'd5,   0, 5'd5,  64'h123,  64'h123,  64'h123};
        tv[2]  = '{5'd31, 5'd4,   0, 5'd31, 64'hDEAD, 64'h0,    64'h9};
        tv[3]  = '{5'd4,  5'd31,  1, 5'd31, 64'hBEEF, 64'h9,    64'h0};
        tv[4]  = '{5'd8,  5'd9,   1, 5'd9,  64'hD9,   64'h1008, 64'hD9};
        tv[5]  = '{5'd10, 5'd11,  1, 5'd10, 64'hEA,   64'hEA,   64'h100B};
        tv[6]  = '{5'd12, 5'd13,  2, 5'd13, 64'hFD,   64'h100C, 64'hFD};
        tv[7]  = '{5'd12, 5'd13,  2, 5'd12, 64'hCC,   64'hCC,   64'hFD};
        tv[8]  = '{5'd14, 5'd15,  3, 5'd14, 64'hEE,   64'h100E, 64'h100F};
        tv[9]  = '{5'd14, 5'd14, -1, 5'd0,  64'h0,    64'hEE,   64'hEE};
        tv[10] = '{5'd6,  5'd6,   0, 5'd6,  64'h66,   64'h66,   64'h66};
        tv[11] = '{5'd0,  5'd1,   2, 5'd0,  64'h77,   64'h77,   64'h1001};

        // Reset state, with a request pending that must be ignored.
        drive_req(5'd5, 5'd6);
        #2;
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        req_valid = 1'b0;
        next_cyc();
        next_cyc();
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        chk("post_rst_data1", rsp_data1, 0);
        chk("post_rst_data2", rsp_data2, 0);

        // Back-to-back table: a fetch every 4 cycles, next request
        // already pending in the response cycle.
        next_cyc();
        rsp_ready = 1'b1;
        drive_req(tv[0].a1, tv[0].a2);
        for (int i = 0; i < NV; i++) begin
            set_wr(i, 0);
            sb.push_back('{d1: tv[i].e1, d2: tv[i].e2});
            @(negedge clk);
            chk("c0_req_ready", req_ready, 1);
            chk("c0_mem_rd_en", mem_rd_en, 1);
            chk("c0_mem_addr", mem_addr, tv[i].a1);
            next_cyc();
            req_valid = 1'b0;
            set_wr(i, 1);
            @(negedge clk);
            chk("c1_mem_rd_en", mem_rd_en, 1);
            chk("c1_mem_addr", mem_addr, tv[i].a2);
            chk("c1_req_ready", req_ready, 0);
            next_cyc();
            set_wr(i, 2);
            @(negedge clk);
            chk("c2_mem_rd_en", mem_rd_en, 0);
            chk("c2_rsp_valid", rsp_valid, 0);
            chk("c2_req_ready", req_ready, 0);
            next_cyc();
            set_wr(i, 3);
            if (i < NV - 1) drive_req(tv[i+1].a1, tv[i+1].a2);
            @(negedge clk);
            chk("c3_rsp_valid", rsp_valid, 1);
            chk("c3_req_ready", req_ready, 0);
            chk("c3_mem_rd_en", mem_rd_en, 0);
            next_cyc();
            wr_en = 1'b0;
        end

        // Stalled response: a write during the stall updates operand 2;
        // a write in the handshake cycle is not reflected.
        rsp_ready = 1'b0;
        drive_req(5'd3, 5'd4);
        sb.push_back('{d1: 64'hAA, d2: 64'h77});
        next_cyc();
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 8);
        chk("stall_rsp_wait", rsp_valid, 1);
        chk("stall_k1_data2", rsp_data2, 64'h9);
        for (int k = 2; k <= 5; k++) begin
            next_cyc();
            wr_en   = (k == 2);
            wr_addr = 5'd4;
            wr_data = 64'h77;
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_data2", rsp_data2, (k >= 3) ? 64'h77 : 64'h9);
            chk("stall_data1", rsp_data1, 64'hAA);
        end
        next_cyc();
        rsp_ready = 1'b1;
        wr_en     = 1'b1;
        wr_addr   = 5'd3;
        wr_data   = 64'h55;
        @(negedge clk);
        next_cyc();
        wr_en = 1'b0;
        @(negedge clk);
        chk("after_rsp_valid", rsp_valid, 0);
        chk("after_req_ready", req_ready, 1);

        // Reset in CAPT2 aborts the fetch with no response.
        next_cyc();
        drive_req(5'd3, 5'd7);
        next_cyc();
        req_valid = 1'b0;
        next_cyc();
        #1;
        reset = 1'b0;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_mem_rd_en", mem_rd_en, 0);
        chk("abort_req_ready", req_ready, 0);
        chk("abort_data2", rsp_data2, 0);
        next_cyc();
        next_cyc();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", rsp_valid, 0);
        end

        // Fresh fetch after reset sees current storage.
        next_cyc();
        drive_req(5'd3, 5'd7);
        sb.push_back('{d1: 64'h55, d2: 64'hBB});
        next_cyc();
        req_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 8);
        chk("fresh_rsp_wait", rsp_valid, 1);
        next_cyc();
        next_cyc();

        chk("sb_empty", 64'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
